// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the BETA ALU shift path. The combinational shifter,
// the ALU decoder and the iterative shifter all use these definitions.
//   SFN_*      : 2-bit shift function encodings
//   shift_st_t : iterative shifter FSM states
//   needs_shift: whether an operation has to pass through the SHIFT state
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [1:0] SFN_SHL = 2'b00;  // logical left
  localparam logic [1:0] SFN_SHR = 2'b01;  // logical right
  localparam logic [1:0] SFN_SRA = 2'b11;  // arithmetic right
  localparam logic [1:0] SFN_RSV = 2'b10;  // reserved: pass-through

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FINISH = 2'b10
  } shift_st_t;

  // A zero shift amount and the reserved function both skip the SHIFT state.
  function automatic logic needs_shift(input logic zero_amt, input logic [1:0] sfn);
    needs_shift = !zero_amt && (sfn != SFN_RSV);
  endfunction

endpackage

// File: rtl/shift1_step.sv
// -----------------------------------------------------------------------------
// shift1_step
// Combinational one-bit shift of a WIDTH-bit vector.
//   din  : vector to shift
//   sfn  : function (SHL / SHR / SRA; reserved passes din through unchanged)
//   dout : din shifted by one position
// -----------------------------------------------------------------------------
module shift1_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sfn,
  output logic [WIDTH-1:0] dout
);

  // Select the fill bit and direction for a single-position shift.
  always_comb begin
    dout = din;
    case (sfn)
      SFN_SHL: dout = {din[WIDTH-2:0], 1'b0};
      SFN_SHR: dout = {1'b0, din[WIDTH-1:1]};
      SFN_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/iter_shift.sv
// -----------------------------------------------------------------------------
// iter_shift
// Multi-cycle, low-area SHL/SHR/SRA unit: one bit position per clock behind
// a START/DONE handshake.
//   CLK     : rising-edge clock
//   RESET_N : asynchronous active-low reset
//   START   : request, accepted in IDLE or FINISH (ignored while BUSY)
//   A       : operand to shift
//   B       : unsigned shift amount, 0..WIDTH-1
//   SFN     : 00 SHL, 01 SHR, 11 SRA, 10 reserved (pass-through)
//   BUSY    : high while shifting
//   DONE    : one-cycle pulse; Y is valid from this cycle on
//   Y       : result register, held until the next result is produced
//
// DONE and Y are registered copies of the FINISH-state outputs. They therefore
// appear one edge after FINISH is entered, which gives a latency of B+1 edges
// (1 edge for B=0 or for the reserved function). With back-to-back operations
// and B=0, Y still presents each result together with its own DONE.
// -----------------------------------------------------------------------------
module iter_shift
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] B,
  input  logic [1:0]         SFN,
  output logic               BUSY,
  output logic               DONE,
  output logic [WIDTH-1:0]   Y
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  shift_st_t          state_r, state_s;
  logic [WIDTH-1:0]   work_r, work_s;
  logic [WIDTH-1:0]   step_s;
  logic [SHAMT_W-1:0] cnt_r, cnt_s;
  logic [1:0]         sfn_r, sfn_s;
  logic               accept_s;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   y_r;

  shift1_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .din  (work_r),
    .sfn  (sfn_r),
    .dout (step_s)
  );

  // A request is taken only when not shifting; START in SHIFT is dropped.
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE:   accept_s = START;
      ST_FINISH: accept_s = START;
      default:   accept_s = 1'b0;
    endcase
  end

  // Next-state, counter and working-register logic.
  always_comb begin
    state_s = state_r;
    work_s  = work_r;
    cnt_s   = cnt_r;
    sfn_s   = sfn_r;
    case (state_r)
      ST_IDLE, ST_FINISH: begin
        if (accept_s) begin
          work_s = A;
          cnt_s  = B;
          sfn_s  = SFN;
          if (needs_shift(B == CNT_ZERO, SFN)) begin
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_FINISH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_s = step_s;
        cnt_s  = cnt_r - CNT_ONE;
        // The counter reaches zero with this shift.
        if (cnt_r == CNT_ONE) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand and working registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      work_r  <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      sfn_r   <= SFN_SHL;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      cnt_r   <= cnt_s;
      sfn_r   <= sfn_s;
    end
  end

  // Registered handshake outputs and the result register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      y_r    <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_s == ST_SHIFT);
      done_r <= (state_r == ST_FINISH);
      if (state_r == ST_FINISH) begin
        y_r <= work_r;
      end else begin
        y_r <= y_r;
      end
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign Y    = y_r;

endmodule

// File: tb/tb_iter_shift.sv
// -----------------------------------------------------------------------------
// tb_iter_shift
// Self-checking bench for iter_shift: a table of directed vectors, randomized
// operations checked against an arithmetic reference model, and hand-written
// sequences for mid-SHIFT START, back-to-back START and reset abort.
// -----------------------------------------------------------------------------
module tb_iter_shift;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [31:0] A;
  logic [4:0]  B;
  logic [1:0]  SFN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Y;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  sfn;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t tbl [0:14];

  iter_shift #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .A       (A),
    .B       (B),
    .SFN     (SFN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .Y       (Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: shift rules written as plain arithmetic.
  function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [4:0] b,
                                        input logic [1:0] sfn);
    case (sfn)
      2'b00:   ref_y = a << b;
      2'b01:   ref_y = a >> b;
      2'b11:   ref_y = $unsigned($signed(a) >>> b);
      default: ref_y = a;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] b, input logic [1:0] sfn);
    if (b == 5'd0 || sfn == 2'b10) ref_lat = 1;
    else ref_lat = int'(b) + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // One operation; inj>=0 pulses START with junk operands at that sample.
  task automatic run_op(input logic [31:0] a, input logic [4:0] b, input logic [1:0] sfn,
                        input logic [31:0] ey, input int elat, input string nm,
                        input int inj);
    int done_at;
    int busy_cnt;
    int ndone;
    done_at  = -1;
    busy_cnt = 0;
    ndone    = 0;
    @(negedge CLK);
    A = a; B = b; SFN = sfn; START = 1'b1;
    @(posedge CLK);
    for (int k = 0; k <= elat + 2; k++) begin
      @(negedge CLK);
      if (k == 0) START = 1'b0;
      if (k == inj) begin
        START = 1'b1; A = ~a; B = 5'd1; SFN = 2'b00;
      end
      if (k == inj + 1) START = 1'b0;
      if (BUSY) busy_cnt++;
      if (DONE) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k;
          chk({nm, " y"}, Y, ey);
        end
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    chk({nm, " latency"}, 32'(done_at), 32'(elat));
    chk({nm, " done_pulses"}, 32'(ndone), 32'd1);
    chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(elat - 1));
    chk({nm, " y_hold"}, Y, ey);
  endtask

  initial begin
    int d0;
    int d1;
    int nd;
    int bad;
    logic [31:0] y0;
    logic [31:0] y1;
    logic [31:0] ra;
    logic [4:0]  rb;
    logic [1:0]  rs;

    checks   = 0;
    failures = 0;
    RESET_N  = 1'b0;
    START    = 1'b0;
    A        = 32'd0;
    B        = 5'd0;
    SFN      = 2'b00;

    tbl[0]  = '{32'd44,         5'd2,  2'b00, 32'd176,        3};
    tbl[1]  = '{32'd44,         5'd7,  2'b00, 32'd5632,       8};
    tbl[2]  = '{32'd144,        5'd6,  2'b01, 32'd2,          7};
    tbl[3]  = '{32'd44,         5'd4,  2'b01, 32'd2,          5};
    tbl[4]  = '{32'h8000_0000,  5'd31, 2'b11, 32'hFFFF_FFFF,  32};
    tbl[5]  = '{32'h8000_0000,  5'd30, 2'b11, 32'hFFFF_FFFE,  31};
    tbl[6]  = '{32'h8000_0000,  5'd15, 2'b11, 32'hFFFF_0000,  16};
    tbl[7]  = '{32'h8000_0000,  5'd2,  2'b11, 32'hE000_0000,  3};
    tbl[8]  = '{32'd1144,       5'd7,  2'b11, 32'd8,          8};
    tbl[9]  = '{32'h1234_5678,  5'd0,  2'b00, 32'h1234_5678,  1};
    tbl[10] = '{32'h1234_5678,  5'd0,  2'b01, 32'h1234_5678,  1};
    tbl[11] = '{32'h1234_5678,  5'd0,  2'b11, 32'h1234_5678,  1};
    tbl[12] = '{32'h1234_5678,  5'd0,  2'b10, 32'h1234_5678,  1};
    tbl[13] = '{32'h1234_5678,  5'd9,  2'b10, 32'h1234_5678,  1};
    tbl[14] = '{32'h0000_0001,  5'd31, 2'b00, 32'h8000_0000,  32};

    // Reset state.
    repeat (2) @(negedge CLK);
    chk("reset y", Y, 32'd0);
    chk("reset busy", {31'd0, BUSY}, 32'd0);
    chk("reset done", {31'd0, DONE}, 32'd0);
    RESET_N = 1'b1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sfn, tbl[i].y, tbl[i].lat,
             $sformatf("vec%0d", i), -10);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = 5'($urandom_range(0, 31));
      rs = 2'($urandom_range(0, 3));
      run_op(ra, rb, rs, ref_y(ra, rb, rs), ref_lat(rb, rs), $sformatf("rand%0d", i), -10);
    end

    // START with new operands mid-SHIFT is dropped.
    run_op(32'd44, 5'd7, 2'b00, 32'd5632, 8, "midshift_start", 3);

    // START held through FINISH: second operation runs back-to-back.
    @(negedge CLK);
    A = 32'd44; B = 5'd2; SFN = 2'b00; START = 1'b1;
    @(posedge CLK);
    d0 = -1; d1 = -1; nd = 0; y0 = 32'd0; y1 = 32'd0;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        A = 32'd144; B = 5'd6; SFN = 2'b01;
      end
      if (k == 3) START = 1'b0;
      if (DONE) begin
        nd++;
        if (d0 < 0) begin
          d0 = k; y0 = Y;
        end else if (d1 < 0) begin
          d1 = k; y1 = Y;
        end
      end
      @(posedge CLK);
    end
    chk("b2b done_pulses", 32'(nd), 32'd2);
    chk("b2b first_latency", 32'(d0), 32'd3);
    chk("b2b first_y", y0, 32'd176);
    chk("b2b second_latency", 32'(d1), 32'd10);
    chk("b2b second_y", y1, 32'd2);

    // Reset mid-SHIFT aborts the operation with no DONE.
    @(negedge CLK);
    A = 32'h0F0F_0001; B = 5'd20; SFN = 2'b00; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("abort y", Y, 32'd0);
    chk("abort busy", {31'd0, BUSY}, 32'd0);
    chk("abort done", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (DONE || BUSY) bad++;
    end
    chk("abort no_done", 32'(bad), 32'd0);
    run_op(32'd1144, 5'd7, 2'b11, 32'd8, 8, "after_abort", -10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
